// File: rtl/cv32e40p_pkg.sv
// Shared types for the LSU: access size encoding and the per-transaction response record.
// CV32E40P_LSU_BUS_ERR_EN adds the full byte address to each response record.
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    HALF = 2'b01,
    BYTE = 2'b10
  } data_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_e;

  typedef struct packed {
    logic       we;
    data_type_e data_type;
    logic       sign_ext;
    logic [1:0] offset;
`ifdef CV32E40P_LSU_BUS_ERR_EN
    logic [31:0] addr;
`endif
  } lsu_resp_t;

  function automatic logic [3:0] be_gen(data_type_e t, logic [1:0] off);
    case (t)
      WORD:    be_gen = 4'b1111;
      HALF:    be_gen = 4'b0011 << off;
      default: be_gen = 4'b0001 << off;
    endcase
  endfunction

endpackage

// File: rtl/cv32e40p_lsu_resp_fifo.sv
// Response FIFO for outstanding bus transactions; a simultaneous pop and push
// on a full FIFO is legal because the head is consumed in the same cycle.
module cv32e40p_lsu_resp_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once their push is counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/cv32e40p_lsu_obi.sv
// Load/store unit driving an OBI data bus with up to DEPTH outstanding transactions.
// CV32E40P_LSU_BUS_ERR_EN adds bus_err_o / bus_err_addr_o reporting of errored responses.
module cv32e40p_lsu_obi
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_ex_i,
  input  logic        data_we_ex_i,
  input  logic [1:0]  data_type_ex_i,
  input  logic        data_sign_ext_ex_i,
  input  logic [31:0] operand_a_ex_i,
  input  logic [31:0] operand_b_ex_i,
  input  logic [31:0] data_wdata_ex_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rvalid_o,
  output logic        misaligned_o,
  output logic        lsu_ready_ex_o,
  output logic        lsu_ready_wb_o,
`ifdef CV32E40P_LSU_BUS_ERR_EN
  output logic        bus_err_o,
  output logic [31:0] bus_err_addr_o,
`endif
  output logic        busy_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      addr;
  logic [1:0]       offset;
  data_type_e       dtype;
  logic             misaligned;
  logic             gnt_ok;
  logic             resp_valid;
  logic [CNT_W-1:0] cnt_q;
  lsu_state_e       state_q;
  lsu_resp_t        push_entry;
  lsu_resp_t        head;
  logic [63:0]      rdata_dbl;
  logic [31:0]      rdata_rot;
  logic             unused_fifo_full;
  logic             unused_fifo_empty;

  assign addr   = operand_a_ex_i + operand_b_ex_i;
  assign offset = addr[1:0];
  assign dtype  = data_type_e'(data_type_ex_i);

  assign misaligned = ((dtype == HALF) && offset[0]) || ((dtype == WORD) && (offset != 2'b00));
  assign misaligned_o = data_req_ex_i & misaligned;

  // A response retiring this cycle frees a slot, so a full FIFO can still issue.
  assign data_req_o = data_req_ex_i & ~misaligned & ((cnt_q < CNT_W'(DEPTH)) | data_rvalid_i);
  assign gnt_ok     = data_req_o & data_gnt_i;
  assign resp_valid = data_rvalid_i & (cnt_q != '0);

  assign data_addr_o  = {addr[31:2], 2'b00};
  assign data_we_o    = data_we_ex_i;
  assign data_be_o    = be_gen(dtype, offset);
  assign data_wdata_o = data_wdata_ex_i << {offset, 3'b000};

  assign lsu_ready_ex_o = ~data_req_ex_i | misaligned | gnt_ok;
  assign lsu_ready_wb_o = (cnt_q == '0) | data_rvalid_i;
  assign busy_o         = (state_q == BUSY) | data_req_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      case ({gnt_ok, resp_valid})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
      case (state_q)
        IDLE:    if (gnt_ok) state_q <= BUSY;
        BUSY:    if (resp_valid && !gnt_ok && (cnt_q == CNT_W'(1))) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    push_entry           = '0;
    push_entry.we        = data_we_ex_i;
    push_entry.data_type = dtype;
    push_entry.sign_ext  = data_sign_ext_ex_i;
    push_entry.offset    = offset;
`ifdef CV32E40P_LSU_BUS_ERR_EN
    push_entry.addr      = addr;
`endif
  end

  cv32e40p_lsu_resp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (lsu_resp_t)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gnt_ok),
    .pop   (resp_valid),
    .wdata (push_entry),
    .rdata (head),
    .full  (unused_fifo_full),
    .empty (unused_fifo_empty)
  );

  assign rdata_dbl    = {data_rdata_i, data_rdata_i};
  assign rdata_rot    = rdata_dbl[{head.offset, 3'b000} +: 32];
  assign lsu_rvalid_o = resp_valid;

  always_comb begin
    lsu_rdata_o = rdata_rot;
    case (head.data_type)
      BYTE:    lsu_rdata_o = {{24{head.sign_ext & rdata_rot[7]}}, rdata_rot[7:0]};
      HALF:    lsu_rdata_o = {{16{head.sign_ext & rdata_rot[15]}}, rdata_rot[15:0]};
      default: ;
    endcase
  end

`ifdef CV32E40P_LSU_BUS_ERR_EN
  assign bus_err_o      = resp_valid & data_err_i;
  assign bus_err_addr_o = head.addr;
`else
  logic unused_data_err;
  assign unused_data_err = data_err_i;
`endif

endmodule
